// File: rtl/wts_tone_sequencer_if.sv
// CPU waveform-write handshake: level request held until a one-cycle ack.
// The sequencer (slave) acks one cycle after the write slot that served the request.
interface wts_tone_sequencer_if;
  logic       cpu_wr_req;
  logic [6:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_ack;

  modport master (output cpu_wr_req, output cpu_wr_addr, output cpu_wr_data, input cpu_wr_ack);
  modport slave  (input cpu_wr_req, input cpu_wr_addr, input cpu_wr_data, output cpu_wr_ack);
endinterface

// File: rtl/wts_tone_sequencer.sv
// Four-channel wavetable sequencer sharing one wave RAM port over an 8-slot frame.
// Read-to-wave latency 2 cycles; CPU writes stall until the next odd slot (ack 1-2 cycles).
module wts_tone_sequencer (
  input  logic                       clk,
  input  logic                       nreset,
  wts_tone_sequencer_if.slave        cpu,
  output logic                       sram_we,
  output logic [6:0]                 sram_a,
  output logic [7:0]                 sram_d,
  input  logic [7:0]                 sram_q,
  input  logic                       freq_we,
  input  logic [1:0]                 freq_ch,
  input  logic [11:0]                freq_d,
  input  logic [3:0]                 key_on,
  output logic [7:0]                 ch0_wave,
  output logic [7:0]                 ch1_wave,
  output logic [7:0]                 ch2_wave,
  output logic [7:0]                 ch3_wave,
  output logic                       frame_strobe
);

  logic [2:0]  slot_q, slot_d;
  logic [11:0] prd_q [4];
  logic [11:0] prd_d [4];
  logic [11:0] cnt_q [4];
  logic [11:0] cnt_d [4];
  logic [4:0]  phase_q [4];
  logic [4:0]  phase_d [4];
  logic [7:0]  wave_q [4];
  logic [7:0]  wave_d [4];
  logic        ack_q, ack_d;
  logic        strobe_q, strobe_d;

  logic [1:0]  ch;
  logic        wr_slot;

  // RAM port: even slots always read, odd slots give priority to a pending CPU write
  always_comb begin
    ch      = slot_q[2:1];
    wr_slot = slot_q[0];
    sram_we = wr_slot & cpu.cpu_wr_req;
    sram_a  = {ch, phase_q[ch]};
    sram_d  = 8'h00;
    if (sram_we) begin
      sram_a = cpu.cpu_wr_addr;
      sram_d = cpu.cpu_wr_data;
    end
  end

  always_comb begin
    slot_d   = slot_q + 3'd1;
    ack_d    = sram_we;
    strobe_d = (slot_q == 3'd7);
    wave_d   = wave_q;
    prd_d    = prd_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;

    // RAM holds its output during a write, so the capture is safe in every odd slot
    if (wr_slot) begin
      wave_d[ch] = sram_q;
    end

    if (freq_we) begin
      prd_d[freq_ch] = freq_d;
    end

    // Reloads read prd_q, so a coincident freq_we only affects the following reload
    if (slot_q == 3'd7) begin
      for (int k = 0; k < 4; k++) begin
        if (!key_on[k]) begin
          phase_d[k] = 5'd0;
          cnt_d[k]   = prd_q[k];
        end else if (prd_q[k] != 12'd0) begin
          if (cnt_q[k] == 12'd0) begin
            cnt_d[k]   = prd_q[k];
            phase_d[k] = phase_q[k] + 5'd1;
          end else begin
            cnt_d[k] = cnt_q[k] - 12'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q   <= 3'd0;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        prd_q[k]   <= 12'd0;
        cnt_q[k]   <= 12'd0;
        phase_q[k] <= 5'd0;
        wave_q[k]  <= 8'h00;
      end
    end else begin
      slot_q   <= slot_d;
      ack_q    <= ack_d;
      strobe_q <= strobe_d;
      for (int k = 0; k < 4; k++) begin
        prd_q[k]   <= prd_d[k];
        cnt_q[k]   <= cnt_d[k];
        phase_q[k] <= phase_d[k];
        wave_q[k]  <= wave_d[k];
      end
    end
  end

  assign cpu.cpu_wr_ack = ack_q;
  assign frame_strobe   = strobe_q;
  assign ch0_wave       = wave_q[0];
  assign ch1_wave       = wave_q[1];
  assign ch2_wave       = wave_q[2];
  assign ch3_wave       = wave_q[3];

endmodule

// File: doc/wts_tone_sequencer.md
# wts_tone_sequencer

Time-multiplexed waveform sequencer for four wavetable channels. It drives the address and write-enable port of the 128x8 wave RAM: every 8-cycle frame it reads one sample per channel, and in the remaining slots it merges CPU waveform writes into the same RAM port. Per-channel 12-bit frequency dividers advance a 5-bit sample index. The latched 8-bit samples go downstream to the mixer, together with a frame strobe.

## Interface
- No parameters. Channel count (4), samples per channel (32) and frame length (8) are fixed.
- clk  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- sram_we  out  1  wave RAM write enable
- sram_a  out  7  wave RAM address, {channel[1:0], index[4:0]}
- sram_d  out  8  wave RAM write data
- sram_q  in  8  wave RAM read data, valid the cycle after a read address is presented with sram_we=0
- cpu_wr_req  in  1  CPU waveform write request, level, held until ack
- cpu_wr_addr  in  7  CPU write address, stable while req=1
- cpu_wr_data  in  8  CPU write data, stable while req=1
- cpu_wr_ack  out  1  one-cycle pulse: write performed
- freq_we  in  1  frequency register write strobe
- freq_ch  in  2  channel selected by freq_we
- freq_d  in  12  frequency (period) value
- key_on  in  4  per-channel run enable
- ch0_wave..ch3_wave  out  8 each  latched sample per channel, two's complement, passed through unmodified
- frame_strobe  out  1  one-cycle pulse: all four chN_wave updated

## Operation
- 3-bit slot counter `slot` free-runs 0..7 and wraps to 0. k = slot>>1.
- Even slot 2k (read slot):
  - sram_we=0, sram_a={k, phase[k]}, sram_d=0.
  - The RAM registers the sample at the end of this slot.
- Odd slot 2k+1 (capture/write slot):
  - The sample on sram_q is captured into chk_wave at the end of the slot.
  - If cpu_wr_req=1 in the same slot: sram_we=1, sram_a=cpu_wr_addr, sram_d=cpu_wr_data. cpu_wr_ack=1 in the next cycle.
  - Otherwise: sram_we=0, sram_a={k, phase[k]}, sram_d=0.
- sram_we, sram_a and sram_d are combinational from slot and the CPU inputs. All other outputs are registered.
- A write never disturbs the captured sample, because the RAM holds its output register during writes.
- Write to the address read in the same frame: the old sample is output this frame and the new sample from the next frame.
- Per channel: freq[k] (12b), cnt[k] (12b down counter), phase[k] (5b). All are updated only at the end of slot 7, so phases are stable for a whole frame.
- End of slot 7, per channel, in priority order:
  - key_on[k]=0: phase←0, cnt←freq[k].
  - Else freq[k]=0: halt; phase and cnt are held.
  - Else cnt=0: cnt←freq[k], phase←phase+1 mod 32 (31 wraps to 0).
  - Else cnt←cnt−1.
- Sample step period is (freq+1) frames = 8·(freq+1) clocks.
- freq_we loads freq[freq_ch] at the clock edge. cnt is not touched; the new value takes effect at the next reload.
- If freq_we and an end-of-slot-7 reload of the same channel coincide, the reload uses the old freq.
- key_on takes effect only at the end of slot 7. The first sample after key-on is index 0, held for freq+1 frames.

## Timing
- Reset state:
  - slot=0, all freq/cnt/phase=0.
  - ch0..ch3_wave=0, cpu_wr_ack=0, frame_strobe=0.
  - sram_we=0, sram_a=0, sram_d=0.
- Latency, read address to chk_wave: the address is presented in slot 2k; chk_wave changes in slot 2k+2 (slot 0 for ch3).
- frame_strobe is high during slot 0, following the ch3 capture at the end of slot 7. The first pulse comes 8 cycles after reset release.
- cpu_wr_req to cpu_wr_ack: 1 cycle if req rises in an odd slot, 2 cycles if in an even slot.
- The requester must drop req, or present new address/data, in the cycle ack is seen. A held req performs one write per odd slot, so up to 4 writes per frame.
- Reset asserted mid-frame: all state returns to reset values immediately. Any pending write is dropped, with no ack. The slot sequence restarts at 0 after release.

## Test plan
- Reset: hold nreset=0, then release → slot restarts at 0; all outputs 0; first frame_strobe at cycle 8.
- CPU fill: write ram[i]=i for all 128 addresses using back-to-back req → exactly 128 acks; each ack falls in an even slot. key_on=4'hF with all freq=0 → ch0..3_wave = 0x00, 0x20, 0x40, 0x60, held.
- Stepping: freq[1]=2, key_on[1]=1 → ch1_wave steps 0x20, 0x21, … every 3 frames (24 clocks); after 0x3F it wraps to 0x20.
- Key-off: with ch1 mid-sequence, drop key_on[1] → at the next frame boundary phase=0; ch1_wave=0x20 from the following frame.
- Write collision: while ch0 plays index 5 (freq=100), write ram[5]=0xA5 at slot 1 → current frame ch0_wave keeps the old value; the next frame shows 0xA5; no other channel is disturbed.
- Frequency change: raise freq from 10 to 1 mid-count → the remaining count of 10 finishes; the steps after that come every 2 frames. Reset asserted mid-write → no ack; ram contents at cpu_wr_addr unchanged.
